// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_port_arbiter
// Description : Shares the single data-memory port between the pipeline MEM
//               stage (CPU) and a DMA/loader engine. Requests are arbitrated
//               round-robin in IDLE. Each access holds the port for MEM_LAT
//               cycles (ACCESS) and is followed by one response cycle (RESP).
//               The CPU pipeline is stalled while its access is pending.
//
// Ports       :
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata        CPU (MEM stage) request side
//   cpu_rdata, cpu_stall         CPU read data and pipeline freeze
//   dma_req/we/addr/wdata        DMA request side (req held until dma_done)
//   dma_rdata, dma_done          DMA read data and one-cycle completion pulse
//   mem_re/we/addr/wdata         data-memory command
//   mem_rdata                    data-memory read data
//
// Revision    : 1.0 - initial release
// ============================================================================
module dm_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,

    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               c_CNT_W    = $clog2(MEM_LAT + 1);
    // The counter is loaded with MEM_LAT-1 at grant so that the last ACCESS
    // cycle is the one where it reads zero.
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic             c_OWN_CPU  = 1'b0;
    localparam logic             c_OWN_DMA  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic                owner_q,      owner_d;
    logic                last_grant_q, last_grant_d;
    logic                we_q,         we_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [DATA_W-1:0]   wdata_q,      wdata_d;
    logic [DATA_W-1:0]   rdata_q,      rdata_d;
    logic [c_CNT_W-1:0]  cnt_q,        cnt_d;

    // ------------------------------------------------------------------------
    // Round-robin grant decision (only consumed in IDLE)
    // ------------------------------------------------------------------------
    logic w_grant_valid;
    logic w_grant_owner;

    always_comb begin
        w_grant_valid = cpu_req | dma_req;
        if (cpu_req && dma_req) begin
            // On a tie the requester that did not win last time goes first.
            w_grant_owner = ~last_grant_q;
        end else begin
            w_grant_owner = dma_req ? c_OWN_DMA : c_OWN_CPU;
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= c_OWN_CPU;
            last_grant_q <= c_OWN_DMA;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and memory-port outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;

        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        dma_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    // Fields are latched here; later changes on the request
                    // side have no effect on the access in flight.
                    owner_d      = w_grant_owner;
                    last_grant_d = w_grant_owner;
                    we_d         = (w_grant_owner == c_OWN_DMA) ? dma_we    : cpu_we;
                    addr_d       = (w_grant_owner == c_OWN_DMA) ? dma_addr  : cpu_addr;
                    wdata_d      = (w_grant_owner == c_OWN_DMA) ? dma_wdata : cpu_wdata;
                    cnt_d        = c_CNT_LOAD;
                    state_d      = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_re    = ~we_q;
                if (cnt_q == '0) begin
                    // Write strobe only in the final cycle so the memory sees
                    // exactly one commit per write access.
                    mem_we  = we_q;
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end

            ST_RESP: begin
                dma_done = (owner_q == c_OWN_DMA);
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Requester-side outputs
    // ------------------------------------------------------------------------
    // The stall drops in exactly the response cycle of a CPU access, so the
    // pipeline advances on that edge and the next request is seen in IDLE.
    assign cpu_stall = cpu_req & ~((state_q == ST_RESP) && (owner_q == c_OWN_CPU));
    assign cpu_rdata = rdata_q;
    assign dma_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_port_arbiter
// Description : Self-checking bench for dm_port_arbiter. Three instances with
//               MEM_LAT = 1, 2, 3 run side by side under independent random
//               CPU/DMA requesters and occasional resets. A transaction-level
//               reference model (grant cycle plus latency arithmetic and a
//               reference memory) predicts every output in every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;

    localparam int N        = 3;
    localparam int NCYC     = 1500;
    localparam int DIR_CYC  = 40;   // opening window of permanent contention
    localparam int RST_CYC  = 3;    // first ACCESS cycle of the first grant
    localparam bit OWN_CPU  = 1'b0;
    localparam bit OWN_DMA  = 1'b1;

    logic clk = 1'b0;
    logic rst;

    logic        cpu_req   [N];
    logic        cpu_we    [N];
    logic [31:0] cpu_addr  [N];
    logic [31:0] cpu_wdata [N];
    logic [31:0] cpu_rdata [N];
    logic        cpu_stall [N];
    logic        dma_req   [N];
    logic        dma_we    [N];
    logic [31:0] dma_addr  [N];
    logic [31:0] dma_wdata [N];
    logic [31:0] dma_rdata [N];
    logic        dma_done  [N];
    logic        mem_re    [N];
    logic        mem_we    [N];
    logic [31:0] mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        dm_port_arbiter #(
            .ADDR_W  (32),
            .DATA_W  (32),
            .MEM_LAT (k + 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cpu_req   (cpu_req[k]),
            .cpu_we    (cpu_we[k]),
            .cpu_addr  (cpu_addr[k]),
            .cpu_wdata (cpu_wdata[k]),
            .cpu_rdata (cpu_rdata[k]),
            .cpu_stall (cpu_stall[k]),
            .dma_req   (dma_req[k]),
            .dma_we    (dma_we[k]),
            .dma_addr  (dma_addr[k]),
            .dma_wdata (dma_wdata[k]),
            .dma_rdata (dma_rdata[k]),
            .dma_done  (dma_done[k]),
            .mem_re    (mem_re[k]),
            .mem_we    (mem_we[k]),
            .mem_addr  (mem_addr[k]),
            .mem_wdata (mem_wdata[k]),
            .mem_rdata (mem_rdata[k])
        );
    end

    // ------------------------------------------------------------------------
    // Scoreboard counters and checking task
    // ------------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [31:0] act,
                               input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Memories: env_mem answers the DUT port, ref_mem belongs to the model
    // ------------------------------------------------------------------------
    logic [31:0] env_mem [bit [33:0]];
    logic [31:0] ref_mem [bit [33:0]];

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    function automatic logic [31:0] env_rd(input int k, input logic [31:0] a);
        bit [33:0] key = {2'(k), a};
        return env_mem.exists(key) ? env_mem[key] : mem_init(a);
    endfunction

    function automatic logic [31:0] ref_rd(input int k, input logic [31:0] a);
        bit [33:0] key = {2'(k), a};
        return ref_mem.exists(key) ? ref_mem[key] : mem_init(a);
    endfunction

    // ------------------------------------------------------------------------
    // Reference model: one transaction record per instance. A transaction
    // granted in cycle s owns the port in cycles s+1 .. s+L and responds in
    // cycle s+L+1; the port is free for a new grant from s+L+2 on.
    // ------------------------------------------------------------------------
    bit          m_busy  [N];
    bit          m_own   [N];
    bit          m_we    [N];
    logic [31:0] m_addr  [N];
    logic [31:0] m_wdata [N];
    int          m_start [N];
    bit          m_last  [N];
    logic [31:0] m_rdata [N];
    bit          cpu_adv [N];   // CPU access finished in the previous cycle
    bit          dma_adv [N];   // DMA access finished in the previous cycle

    function automatic int phase_of(input int k, input int c);
        return m_busy[k] ? (c - m_start[k]) : -1;
    endfunction

    task automatic check_cycle(input int k, input int c);
        int L    = k + 1;
        int ph   = phase_of(k, c);
        bit acc  = (ph >= 1) && (ph <= L);
        bit resp = (ph == L + 1);
        bit e_re    = acc && !m_we[k];
        bit e_we    = acc && m_we[k] && (ph == L);
        bit e_done  = resp && (m_own[k] == OWN_DMA);
        bit e_stall = cpu_req[k] && !(resp && (m_own[k] == OWN_CPU));
        logic [31:0] e_addr  = acc ? m_addr[k]  : 32'h0;
        logic [31:0] e_wdata = acc ? m_wdata[k] : 32'h0;
        string p = $sformatf("L%0d c%0d", L, c);

        check_value({p, " mem_re"},    32'(mem_re[k]),    32'(e_re));
        check_value({p, " mem_we"},    32'(mem_we[k]),    32'(e_we));
        check_value({p, " mem_addr"},  mem_addr[k],       e_addr);
        check_value({p, " mem_wdata"}, mem_wdata[k],      e_wdata);
        check_value({p, " cpu_stall"}, 32'(cpu_stall[k]), 32'(e_stall));
        check_value({p, " dma_done"},  32'(dma_done[k]),  32'(e_done));
        check_value({p, " cpu_rdata"}, cpu_rdata[k],      m_rdata[k]);
        check_value({p, " dma_rdata"}, dma_rdata[k],      m_rdata[k]);

        cpu_adv[k] = cpu_req[k] && !e_stall;
        dma_adv[k] = e_done;
    endtask

    task automatic model_step(input int k, input int c);
        int L    = k + 1;
        int ph   = phase_of(k, c);
        bit last = (ph == L);
        logic [31:0] old = ref_rd(k, m_addr[k]);

        // The write strobe was visible during this cycle, so the memory
        // commits it even if reset is also asserted at this edge.
        if (last && m_we[k]) ref_mem[{2'(k), m_addr[k]}] = m_wdata[k];

        if (rst) begin
            m_busy[k]  = 1'b0;
            m_last[k]  = OWN_DMA;
            m_rdata[k] = 32'h0;
        end else if (last) begin
            m_rdata[k] = old;
        end else if (ph == L + 1) begin
            m_busy[k] = 1'b0;
        end else if (!m_busy[k] && (cpu_req[k] || dma_req[k])) begin
            bit who;
            if (cpu_req[k] && dma_req[k]) who = (m_last[k] == OWN_DMA) ? OWN_CPU : OWN_DMA;
            else                          who = dma_req[k] ? OWN_DMA : OWN_CPU;
            m_busy[k]  = 1'b1;
            m_own[k]   = who;
            m_last[k]  = who;
            m_start[k] = c;
            m_we[k]    = (who == OWN_DMA) ? dma_we[k]    : cpu_we[k];
            m_addr[k]  = (who == OWN_DMA) ? dma_addr[k]  : cpu_addr[k];
            m_wdata[k] = (who == OWN_DMA) ? dma_wdata[k] : cpu_wdata[k];
        end
    endtask

    // ------------------------------------------------------------------------
    // Requesters
    // ------------------------------------------------------------------------
    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 7)) << 2;
    endfunction

    task automatic new_cpu(input int k, input bit force_wr);
        cpu_req[k]   = 1'b1;
        cpu_we[k]    = force_wr ? 1'b1 : 1'($urandom_range(0, 1));
        cpu_addr[k]  = rnd_addr();
        cpu_wdata[k] = $urandom;
    endtask

    task automatic new_dma(input int k, input bit force_wr);
        dma_req[k]   = 1'b1;
        dma_we[k]    = force_wr ? 1'b1 : 1'($urandom_range(0, 1));
        dma_addr[k]  = rnd_addr();
        dma_wdata[k] = $urandom;
    endtask

    task automatic drive_inputs(input int c);
        if (c < 2 || c == RST_CYC) rst = 1'b1;
        else if (c < DIR_CYC)      rst = 1'b0;
        else                       rst = ($urandom_range(0, 127) == 0);

        for (int k = 0; k < N; k++) begin
            if (c < DIR_CYC) begin
                // Both sides permanently requesting; first ops are writes.
                if (!cpu_req[k] || cpu_adv[k]) new_cpu(k, c < RST_CYC + 1);
                if (!dma_req[k] || dma_adv[k]) new_dma(k, c < RST_CYC + 1);
            end else begin
                if (cpu_req[k]) begin
                    if (cpu_adv[k]) begin
                        if ($urandom_range(0, 9) < 6) new_cpu(k, 1'b0);
                        else cpu_req[k] = 1'b0;
                    end else if ($urandom_range(0, 99) < 2) begin
                        cpu_req[k] = 1'b0;
                    end else if (m_busy[k] && m_own[k] == OWN_CPU &&
                                 $urandom_range(0, 9) == 0) begin
                        cpu_addr[k]  = rnd_addr();
                        cpu_wdata[k] = $urandom;
                    end
                end else if ($urandom_range(0, 9) < 4) begin
                    new_cpu(k, 1'b0);
                end else begin
                    cpu_addr[k]  = rnd_addr();
                    cpu_wdata[k] = $urandom;
                end

                if (dma_req[k]) begin
                    if (dma_adv[k]) begin
                        if ($urandom_range(0, 9) < 5) new_dma(k, 1'b0);
                        else dma_req[k] = 1'b0;
                    end else if ($urandom_range(0, 99) < 2) begin
                        dma_req[k] = 1'b0;
                    end else if (m_busy[k] && m_own[k] == OWN_DMA &&
                                 $urandom_range(0, 9) == 0) begin
                        dma_addr[k]  = rnd_addr();
                        dma_wdata[k] = $urandom;
                    end
                end else if ($urandom_range(0, 9) < 3) begin
                    new_dma(k, 1'b0);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
            dma_req[k] = 1'b0; dma_we[k] = 1'b0; dma_addr[k] = '0; dma_wdata[k] = '0;
            mem_rdata[k] = '0;
            m_busy[k] = 1'b0; m_own[k] = OWN_CPU; m_we[k] = 1'b0;
            m_addr[k] = '0; m_wdata[k] = '0; m_start[k] = 0;
            m_last[k] = OWN_DMA; m_rdata[k] = '0;
            cpu_adv[k] = 1'b0; dma_adv[k] = 1'b0;
        end
        #1;

        for (int c = 0; c < NCYC; c++) begin
            drive_inputs(c);
            @(negedge clk);
            for (int k = 0; k < N; k++) mem_rdata[k] = env_rd(k, mem_addr[k]);
            if (c > 0) begin
                for (int k = 0; k < N; k++) check_cycle(k, c);
            end
            for (int k = 0; k < N; k++) begin
                if (mem_we[k] === 1'b1) env_mem[{2'(k), mem_addr[k]}] = mem_wdata[k];
            end
            for (int k = 0; k < N; k++) model_step(k, c);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the pipeline MEM stage (CPU) and a DMA/loader engine.
- Round-robin arbitration across requesters; each memory access occupies a parameterised number of cycles.
- Stalls the CPU pipeline while its access is pending.
- Sits between the EX/MEM pipeline register outputs and the DM block; the DMA connects on the second port.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles one access holds the memory port (legal range >= 1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU access request (MEM stage Mem_r | Mem_w)
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, valid while cpu_stall=0 after a CPU read
cpu_stall  out  1  freeze pipeline (drives PC/IF-ID/ID-EX/EX-MEM hold)
dma_req  in  1  DMA request, held until dma_done
dma_we  in  1  DMA write enable
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_rdata  out  DATA_W  DMA read data, valid in dma_done cycle
dma_done  out  1  one-cycle completion pulse
mem_re  out  1  DM read enable
mem_we  out  1  DM write enable
mem_addr  out  ADDR_W  DM address
mem_wdata  out  DATA_W  DM write data
mem_rdata  in  DATA_W  DM read data

Behaviour:
- State machine: IDLE, ACCESS, RESP.
- Registers:
  - owner (CPU/DMA)
  - last_grant
  - latched we, addr, wdata
  - rdata_q
  - cnt, width $clog2(MEM_LAT+1)
- Reset (rst=1 at an edge): state=IDLE, cnt=0, last_grant=DMA, rdata_q=0, latched fields=0.
  - All outputs 0 next cycle, including dma_done; cpu_stall follows its equation (below).
  - An access in flight is abandoned: no done pulse, and no mem_we if reset precedes the final ACCESS cycle.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant the one not equal to last_grant.
  - On grant: latch owner/we/addr/wdata, set last_grant=owner, cnt=MEM_LAT-1, go to ACCESS.
  - No req: stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata driven from the latched fields.
  - mem_re = ~we, every ACCESS cycle.
  - mem_we = we only when cnt==0, so a write commits exactly once.
  - cnt decrements each cycle.
  - When cnt==0: rdata_q <= mem_rdata, go to RESP.
- RESP, one cycle:
  - owner=CPU: cpu_rdata=rdata_q.
  - owner=DMA: dma_done=1, dma_rdata=rdata_q.
  - Next state is IDLE. No grant is made in RESP; arbitration always takes one IDLE cycle.
- Outside IDLE, mem_* = 0 except during ACCESS as above.
- cpu_stall is combinational: cpu_stall = cpu_req & ~(state==RESP & owner==CPU).
  - It therefore falls in exactly the RESP cycle of the CPU's access.
  - The pipeline advances at that edge, and the next instruction's request is seen in IDLE.
- Latency: request sampled in IDLE at cycle t; ACCESS covers t+1..t+MEM_LAT; RESP at t+MEM_LAT+1.
  - CPU stall length = MEM_LAT+1 cycles.
- Requester rules:
  - Hold req and fields stable until done/stall release.
  - Changes to the fields after the grant are ignored, because the fields are latched.
- Dropped requests: a requester deasserting req mid-access still completes that access. dma_done still pulses; cpu_stall stays low.
- cpu_rdata and dma_rdata hold rdata_q at all times; they are only meaningful in the stated cycles.
- MEM_LAT=1: ACCESS lasts one cycle with cnt==0, so mem_we and the capture happen in the same cycle.

Test Plan:
1. CPU read only, MEM_LAT=2, addr 0x10, mem_rdata=0xDEADBEEF:
   - mem_re=1 for 2 cycles.
   - cpu_stall=1 for cycles t..t+2, 0 at t+3.
   - cpu_rdata=0xDEADBEEF.
2. CPU write 0x0000_00AB to 0x20:
   - mem_we=1 in exactly one cycle (the last ACCESS cycle), with mem_addr=0x20 and mem_wdata=0xAB.
   - mem_re=0 throughout.
3. cpu_req and dma_req both asserted from reset, both held:
   - Grant order CPU, DMA, CPU, DMA (alternating).
   - Exactly one RESP per access.
   - dma_done pulses once per DMA access.
4. DMA write followed by a CPU read of the same address (DM model):
   - CPU reads the DMA-written value.
   - cpu_stall lasts MEM_LAT+1 cycles measured from the IDLE grant, preceded by the cycles the DMA occupies the port.
5. rst asserted during the first ACCESS cycle of a write (MEM_LAT=3):
   - mem_we is never asserted; no dma_done.
   - state=IDLE and last_grant=DMA after reset; the next tie is granted to the CPU.
6. MEM_LAT=1, back-to-back CPU reads:
   - Each read is stalled 2 cycles.
   - IDLE→ACCESS→RESP→IDLE repeats with period 3.
